// File: rtl/updown_counter_7seg.sv
// Push-button driven up/down modulo counter with a decimal seven-segment readout.
// A synchronised press yields exactly one count event. Wrap or saturate is chosen per instance.
module updown_counter_7seg #(
  parameter int MOD    = 5,
  parameter int DIGITS = 1,
  parameter int WRAP   = 1,
  localparam int CW    = $clog2(MOD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  input  logic                up,
  input  logic                hold,
  input  logic                load,
  input  logic [CW-1:0]       load_val,
  output logic [CW-1:0]       count,
  output logic                wrap_pulse,
  output logic [7*DIGITS-1:0] HEX
);

  localparam logic [CW-1:0] MAX = CW'(MOD - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {
    ST_ARMED,
    ST_PRESSED
  } state_t;

  logic                r_s1, r_s2;
  state_t              r_state, w_state_nxt;
  logic                w_ev;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic [7*DIGITS-1:0] r_hex, w_hex_nxt;
  logic [31:0]         w_rem;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Sync flops and FSM reset to "pressed", so a key held through reset must be released first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_state <= ST_PRESSED;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values; blocking here would collapse the synchroniser.
      r_s1    <= step;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_ev        = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (r_s2) begin
          w_ev        = 1'b1;
          w_state_nxt = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (!r_s2) w_state_nxt = ST_ARMED;
      end
      default: w_state_nxt = ST_PRESSED;
    endcase
  end

  // Load beats hold, hold beats a step event; a discarded event is never replayed.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      w_count_nxt = (load_val > MAX) ? MAX : load_val;
    end else if (!hold && w_ev) begin
      if (up) begin
        if (r_count == MAX) begin
          if (WRAP != 0) begin
            w_count_nxt = '0;
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + ONE;
        end
      end else begin
        if (r_count == '0) begin
          if (WRAP != 0) begin
            w_count_nxt = MAX;
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count - ONE;
        end
      end
    end
  end

  always_comb begin
    w_hex_nxt = '0;
    w_rem     = 32'(r_count);
    for (int i = 0; i < DIGITS; i++) begin
      w_hex_nxt[7*i +: 7] = seg7(4'(w_rem % 32'd10));
      w_rem               = w_rem / 32'd10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_hex   <= {DIGITS{7'b1000000}};
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
      r_hex   <= w_hex_nxt;
    end
  end

  assign count      = r_count;
  assign wrap_pulse = r_wrap;
  assign HEX        = r_hex;

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Bench for updown_counter_7seg: three configurations share one stimulus stream and are
// compared every cycle against an event-level reference model.
module tb_updown_counter_7seg;

  logic        clk = 1'b0;
  logic        reset, step, up, hold, load;
  logic [2:0]  lv5;
  logic [3:0]  lv12;

  logic [2:0]  cnt_w, cnt_s;
  logic [3:0]  cnt_d;
  logic        wp_w, wp_s, wp_d;
  logic [6:0]  hex_w, hex_s;
  logic [13:0] hex_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_counter_7seg #(.MOD(5), .DIGITS(1), .WRAP(1)) u_w (
    .clk(clk), .reset(reset), .step(step), .up(up), .hold(hold), .load(load),
    .load_val(lv5), .count(cnt_w), .wrap_pulse(wp_w), .HEX(hex_w));

  updown_counter_7seg #(.MOD(5), .DIGITS(1), .WRAP(0)) u_s (
    .clk(clk), .reset(reset), .step(step), .up(up), .hold(hold), .load(load),
    .load_val(lv5), .count(cnt_s), .wrap_pulse(wp_s), .HEX(hex_s));

  updown_counter_7seg #(.MOD(12), .DIGITS(2), .WRAP(1)) u_d (
    .clk(clk), .reset(reset), .step(step), .up(up), .hold(hold), .load(load),
    .load_val(lv12), .count(cnt_d), .wrap_pulse(wp_d), .HEX(hex_d));

  // Reference model: a count event is a rising edge of step seen two samples late,
  // with the history primed to "high" at reset.
  int  m_mod    [3] = '{5, 5, 12};
  int  m_digits [3] = '{1, 1, 2};
  bit  m_wrapm  [3] = '{1'b1, 1'b0, 1'b1};
  int  m_cnt    [3];
  int  m_shown  [3];
  bit  m_wp     [3];
  bit  d1, d2, dp;
  int  wp_seen  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_hex(input int v, input int nd);
    logic [31:0] r;
    logic [6:0]  seg;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      case (x % 10)
        0: seg = 7'b1000000;  1: seg = 7'b1111001;
        2: seg = 7'b0100100;  3: seg = 7'b0110000;
        4: seg = 7'b0011001;  5: seg = 7'b0010010;
        6: seg = 7'b0000010;  7: seg = 7'b1111000;
        8: seg = 7'b0000000;  default: seg = 7'b0010000;
      endcase
      r[7*i +: 7] = seg;
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    d1 = 1'b1; d2 = 1'b1; dp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_shown[i] = 0; m_wp[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ev;
    int lv, top;
    ev = d2 && !dp;
    for (int i = 0; i < 3; i++) begin
      lv  = (i == 2) ? int'(lv12) : int'(lv5);
      top = m_mod[i] - 1;
      m_shown[i] = m_cnt[i];
      m_wp[i]    = 1'b0;
      if (load) begin
        m_cnt[i] = (lv > top) ? top : lv;
      end else if (!hold && ev) begin
        if (up) begin
          if (m_cnt[i] < top)  m_cnt[i]++;
          else if (m_wrapm[i]) begin m_cnt[i] = 0;   m_wp[i] = 1'b1; end
        end else begin
          if (m_cnt[i] > 0)    m_cnt[i]--;
          else if (m_wrapm[i]) begin m_cnt[i] = top; m_wp[i] = 1'b1; end
        end
      end
    end
    dp = d2; d2 = d1; d1 = step;
  endtask

  task automatic compare_all();
    check("cnt_w", 32'(cnt_w), 32'(m_cnt[0]));
    check("cnt_s", 32'(cnt_s), 32'(m_cnt[1]));
    check("cnt_d", 32'(cnt_d), 32'(m_cnt[2]));
    check("wp_w",  32'(wp_w),  32'(m_wp[0]));
    check("wp_s",  32'(wp_s),  32'(m_wp[1]));
    check("wp_d",  32'(wp_d),  32'(m_wp[2]));
    check("hex_w", 32'(hex_w), exp_hex(m_shown[0], m_digits[0]));
    check("hex_s", 32'(hex_s), exp_hex(m_shown[1], m_digits[1]));
    check("hex_d", 32'(hex_d), exp_hex(m_shown[2], m_digits[2]));
    if (wp_w === 1'b1) wp_seen[0]++;
    if (wp_s === 1'b1) wp_seen[1]++;
    if (wp_d === 1'b1) wp_seen[2]++;
  endtask

  // One clock: model advances at the rising edge, outputs compared at the falling edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic press(input int hi, input int lo);
    step = 1'b1; tick(hi);
    step = 1'b0; tick(lo);
  endtask

  task automatic do_load(input logic [2:0] v5, input logic [3:0] v12);
    lv5 = v5; lv12 = v12; load = 1'b1; tick(1);
    load = 1'b0; tick(1);
  endtask

  task automatic async_reset(input int cycles);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all();
    tick(cycles);
    reset = 1'b1;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 3; i++) wp_seen[i] = 0;
  endtask

  initial begin
    reset = 1'b0; step = 1'b0; up = 1'b1; hold = 1'b0; load = 1'b0;
    lv5 = '0; lv12 = '0;
    clear_seen();
    model_reset();
    tick(3);
    reset = 1'b1;
    tick(2);
    check("rst_cnt", 32'(cnt_w), 32'd0);
    check("rst_hex", 32'(hex_w), 32'h40);
    check("rst_wp",  32'(wp_w),  32'd0);

    // Six up presses: 1,2,3,4,0,1 with one wrap on the wrapping instance.
    clear_seen();
    up = 1'b1;
    repeat (6) press(3, 3);
    check("t2_cnt_w",  32'(cnt_w), 32'd1);
    check("t2_wraps",  32'(wp_seen[0]), 32'd1);
    check("t2_cnt_s",  32'(cnt_s), 32'd4);
    check("t2_cnt_d",  32'(cnt_d), 32'd6);
    check("t2_hex_w",  32'(hex_w), 32'h79);

    // Down from zero: wrap to MOD-1 vs saturate at 0.
    do_load(3'd0, 4'd0);
    clear_seen();
    up = 1'b0;
    press(3, 3);
    check("t3_cnt_w",  32'(cnt_w), 32'd4);
    check("t3_wrap_w", 32'(wp_seen[0]), 32'd1);
    check("t3_cnt_s",  32'(cnt_s), 32'd0);
    check("t3_wrap_s", 32'(wp_seen[1]), 32'd0);

    // Long press counts once; hold swallows a press.
    do_load(3'd2, 4'd2);
    up = 1'b1;
    press(20, 3);
    check("t4_long", 32'(cnt_w), 32'd3);
    hold = 1'b1;
    press(3, 3);
    hold = 1'b0;
    tick(2);
    check("t4_hold", 32'(cnt_w), 32'd3);

    // Clamped load on the two-digit instance, then load colliding with a press.
    do_load(3'd7, 4'd15);
    check("t5_cnt_d", 32'(cnt_d), 32'd11);
    check("t5_hex_d", 32'(hex_d), 32'h3CF9);
    check("t5_clamp", 32'(cnt_w), 32'd4);
    lv5 = 3'd1; lv12 = 4'd3; load = 1'b1; step = 1'b1;
    tick(4);
    load = 1'b0; step = 1'b0;
    tick(3);
    check("t5_loadwin", 32'(cnt_d), 32'd3);

    // Key held across reset release: nothing until released and pressed again.
    step = 1'b1;
    tick(2);
    async_reset(2);
    tick(5);
    check("t6_held", 32'(cnt_w), 32'd0);
    step = 1'b0; tick(3);
    press(3, 3);
    check("t6_after", 32'(cnt_w), 32'd1);

    // Randomised traffic with occasional hold, load and reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset($urandom_range(1, 3));
      end else begin
        if ($urandom_range(0, 3) == 0) step = ~step;
        up   = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 9) == 0);
        load = ($urandom_range(0, 19) == 0);
        lv5  = 3'($urandom);
        lv12 = 4'($urandom);
        tick(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
